// File: rtl/ram_access_sequencer.sv
// Sequencer that owns the port of the 16-entry switch-store RAM. It serialises
// user store/step requests, runs a bulk clear and an auto-scan, and keeps the display fed.
module ram_access_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int STEP_TICKS = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              store_pulse,
    input  logic              up_pulse,
    input  logic              down_pulse,
    input  logic              clear_pulse,
    input  logic              auto_en,
    input  logic [DATA_W-1:0] sw,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] display_value,
    output logic              busy
);

    localparam int TICK_W = $clog2(STEP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR,
        S_READ,
        S_LATCH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   disp_q, disp_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;

    logic                last_tick;
    logic                one_step;
    logic                user_accept;

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                    input logic            dn);
        addr_step = dn ? (a - ADDR_W'(1)) : (a + ADDR_W'(1));
    endfunction

    assign last_tick   = (tick_q == TICK_W'(STEP_TICKS - 1));
    assign one_step    = up_pulse ^ down_pulse;
    assign user_accept = (state_q == S_IDLE) && (clear_pulse || store_pulse || one_step);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        clr_idx_d  = clr_idx_q;
        wdata_d    = wdata_q;
        disp_d     = disp_q;

        unique case (state_q)
            S_IDLE: begin
                // Pulses arriving in any other state are simply not looked at.
                if (clear_pulse) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end else if (store_pulse) begin
                    state_d = S_WRITE;
                    wdata_d = sw;
                end else if (one_step) begin
                    cur_addr_d = addr_step(cur_addr_q, down_pulse);
                    state_d    = S_READ;
                end else if (auto_en && last_tick) begin
                    cur_addr_d = addr_step(cur_addr_q, 1'b0);
                    state_d    = S_READ;
                end
            end
            S_WRITE: state_d = S_READ;
            S_CLEAR: begin
                if (clr_idx_q == '1) begin
                    cur_addr_d = '0;
                    state_d    = S_READ;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                disp_d  = ram_dout;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan counter only advances while idle; a user action restarts the period.
    always_comb begin
        tick_d = tick_q;
        if (!auto_en) begin
            tick_d = '0;
        end else if (state_q == S_IDLE) begin
            if (user_accept || last_tick) begin
                tick_d = '0;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // RAM port and busy are registered from the next state so they line up with it.
    always_comb begin
        we_d   = (state_d == S_WRITE) || (state_d == S_CLEAR);
        adr_d  = (state_d == S_CLEAR) ? clr_idx_d : cur_addr_d;
        din_d  = (state_d == S_CLEAR) ? '0 : wdata_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_READ;
            cur_addr_q <= '0;
            clr_idx_q  <= '0;
            tick_q     <= '0;
            wdata_q    <= '0;
            disp_q     <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            din_q      <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            clr_idx_q  <= clr_idx_d;
            tick_q     <= tick_d;
            wdata_q    <= wdata_d;
            disp_q     <= disp_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_we        = we_q;
    assign ram_adr       = adr_q;
    assign ram_din       = din_q;
    assign cur_addr      = cur_addr_q;
    assign display_value = disp_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: behavioural synchronous RAM, a table of single
// commands with hand-computed results, and directed clear/auto-scan/reset sequences.
module tb_ram_access_sequencer;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int ST = 4;

    typedef enum {C_STORE, C_UP, C_DOWN, C_CLEAR, C_BOTH} cmd_e;

    typedef struct {
        cmd_e          cmd;
        logic [DW-1:0] swv;
        logic [AW-1:0] addr;
        logic [DW-1:0] disp;
        int            nbusy;
        int            nwr;
    } vec_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] din;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          store_pulse = 1'b0;
    logic          up_pulse = 1'b0;
    logic          down_pulse = 1'b0;
    logic          clear_pulse = 1'b0;
    logic          auto_en = 1'b0;
    logic [DW-1:0] sw = '0;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] display_value;
    logic          busy;

    logic          pl_en = 1'b0;
    logic [DW-1:0] pl_base = '0;
    logic [DW-1:0] mem [16];
    int            cyc = 0;
    wr_t           wr_log [$];

    int n_cmp = 0;
    int n_err = 0;

    ram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .STEP_TICKS(ST)) dut (
        .clk(clk), .reset(reset), .store_pulse(store_pulse), .up_pulse(up_pulse),
        .down_pulse(down_pulse), .clear_pulse(clear_pulse), .auto_en(auto_en), .sw(sw),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
        .cur_addr(cur_addr), .display_value(display_value), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= pl_base + DW'(i);
        end else if (ram_we) begin
            mem[ram_adr] <= ram_din;
            wr_log.push_back('{adr: ram_adr, din: ram_din, cyc: cyc});
        end
        ram_dout <= mem[ram_adr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input cmd_e c, input logic [DW-1:0] s);
        sw          = s;
        store_pulse = (c == C_STORE);
        up_pulse    = (c == C_UP) || (c == C_BOTH);
        down_pulse  = (c == C_DOWN) || (c == C_BOTH);
        clear_pulse = (c == C_CLEAR);
        tick();
        store_pulse = 1'b0;
        up_pulse    = 1'b0;
        down_pulse  = 1'b0;
        clear_pulse = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    vec_t vecs [$];

    function automatic vec_t mk(cmd_e c, logic [DW-1:0] s, logic [AW-1:0] a,
                                logic [DW-1:0] d, int nb, int nw);
        vec_t v;
        v.cmd = c; v.swv = s; v.addr = a; v.disp = d; v.nbusy = nb; v.nwr = nw;
        return v;
    endfunction

    initial begin
        int nb;
        int base;
        logic [AW-1:0] pre;
        logic [AW-1:0] start;
        logic ok;
        int steps;

        vecs.push_back(mk(C_STORE, 16'h1234, 4'd0,  16'h1234, 3, 1));
        vecs.push_back(mk(C_DOWN,  16'h0000, 4'd15, 16'hA00F, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd0,  16'h1234, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd1,  16'hA001, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd2,  16'hA002, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd3,  16'hA003, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd4,  16'hA004, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd5,  16'hA005, 2, 0));
        vecs.push_back(mk(C_STORE, 16'hBEEF, 4'd5,  16'hBEEF, 3, 1));
        vecs.push_back(mk(C_BOTH,  16'h0000, 4'd5,  16'hBEEF, 0, 0));
        vecs.push_back(mk(C_CLEAR, 16'h0000, 4'd0,  16'h0000, 18, 16));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd1,  16'h0000, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd2,  16'h0000, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd3,  16'h0000, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd4,  16'h0000, 2, 0));
        vecs.push_back(mk(C_UP,    16'h0000, 4'd5,  16'h0000, 2, 0));
        vecs.push_back(mk(C_DOWN,  16'h0000, 4'd4,  16'h0000, 2, 0));

        // Reset values and post-reset load of address 0.
        #1 reset = 1'b1;
        #1;
        chk("rst_we",   32'(ram_we), 32'd0);
        chk("rst_adr",  32'(ram_adr), 32'd0);
        chk("rst_din",  32'(ram_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cur",  32'(cur_addr), 32'd0);
        chk("rst_disp", 32'(display_value), 32'd0);
        pl_base = 16'hA000;
        pl_en   = 1'b1;
        tick();
        tick();
        pl_en = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_rst_busy1", 32'(busy), 32'd1);
        tick();
        chk("post_rst_busy2", 32'(busy), 32'd0);
        chk("post_rst_disp",  32'(display_value), 32'hA000);

        for (int k = 0; k < vecs.size(); k++) begin
            pre  = cur_addr;
            base = wr_log.size();
            pulse(vecs[k].cmd, vecs[k].swv);
            case (vecs[k].cmd)
                C_UP, C_DOWN: begin
                    chk($sformatf("v%0d_rdadr", k), 32'(ram_adr), 32'(vecs[k].addr));
                    chk($sformatf("v%0d_cur0", k),  32'(cur_addr), 32'(vecs[k].addr));
                end
                C_STORE: begin
                    chk($sformatf("v%0d_we", k),   32'(ram_we), 32'd1);
                    chk($sformatf("v%0d_wadr", k), 32'(ram_adr), 32'(pre));
                    chk($sformatf("v%0d_wdin", k), 32'(ram_din), 32'(vecs[k].swv));
                end
                C_CLEAR: begin
                    chk($sformatf("v%0d_we", k),   32'(ram_we), 32'd1);
                    chk($sformatf("v%0d_cadr", k), 32'(ram_adr), 32'd0);
                end
                default: chk($sformatf("v%0d_we", k), 32'(ram_we), 32'd0);
            endcase
            count_busy(nb);
            chk($sformatf("v%0d_busy", k), 32'(nb), 32'(vecs[k].nbusy));
            chk($sformatf("v%0d_cur", k),  32'(cur_addr), 32'(vecs[k].addr));
            chk($sformatf("v%0d_disp", k), 32'(display_value), 32'(vecs[k].disp));
            chk($sformatf("v%0d_nwr", k),  32'(wr_log.size() - base), 32'(vecs[k].nwr));
            if (vecs[k].cmd == C_STORE && wr_log.size() > base) begin
                chk($sformatf("v%0d_logadr", k), 32'(wr_log[base].adr), 32'(pre));
                chk($sformatf("v%0d_logdin", k), 32'(wr_log[base].din), 32'(vecs[k].swv));
            end
            if (vecs[k].cmd == C_CLEAR && wr_log.size() - base == 16) begin
                ok = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (wr_log[base+i].adr != AW'(i) || wr_log[base+i].din != '0 ||
                        wr_log[base+i].cyc != wr_log[base].cyc + i) ok = 1'b0;
                end
                chk($sformatf("v%0d_clrseq", k), 32'(ok), 32'd1);
            end
        end

        // Store and up pulses during a clear are dropped.
        base = wr_log.size();
        pulse(C_CLEAR, 16'h0000);
        repeat (4) tick();
        sw          = 16'hFFFF;
        store_pulse = 1'b1;
        up_pulse    = 1'b1;
        tick();
        store_pulse = 1'b0;
        up_pulse    = 1'b0;
        count_busy(nb);
        chk("busyclr_busy", 32'(nb + 5), 32'd18);
        chk("busyclr_nwr",  32'(wr_log.size() - base), 32'd16);
        ok = 1'b1;
        for (int i = base; i < wr_log.size(); i++) if (wr_log[i].din != '0) ok = 1'b0;
        chk("busyclr_din0", 32'(ok), 32'd1);
        chk("busyclr_cur",  32'(cur_addr), 32'd0);

        // Free-running auto-scan: a step every 4 idle cycles plus the 2-cycle read.
        start   = cur_addr;
        auto_en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            steps = (n >= 4) ? ((n - 4) / 6 + 1) : 0;
            chk($sformatf("auto_n%0d", n), 32'(cur_addr), 32'((int'(start) + steps) % 16));
        end
        auto_en = 1'b0;
        count_busy(nb);
        chk("auto_stop_busy", 32'(busy), 32'd0);

        // User up beats or pre-empts the scan and restarts its period.
        start   = cur_addr;
        auto_en = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            up_pulse = (n == 3) || (n == 15);
            tick();
            up_pulse = 1'b0;
            steps = int'(n >= 3) + int'(n >= 9) + int'(n >= 15) + int'(n >= 21);
            chk($sformatf("auto_up_n%0d", n), 32'(cur_addr), 32'((int'(start) + steps) % 16));
        end
        auto_en = 1'b0;
        count_busy(nb);

        // Reset in the middle of a clear, while index 7 is being written.
        pl_base = 16'hC000;
        pl_en   = 1'b1;
        tick();
        pl_en = 1'b0;
        base  = wr_log.size();
        pulse(C_CLEAR, 16'h0000);
        repeat (7) tick();
        chk("midclr_adr7", 32'(ram_adr), 32'd7);
        chk("midclr_we",   32'(ram_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("midclr_rst_we",   32'(ram_we), 32'd0);
        chk("midclr_rst_adr",  32'(ram_adr), 32'd0);
        chk("midclr_rst_din",  32'(ram_din), 32'd0);
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        chk("midclr_rst_cur",  32'(cur_addr), 32'd0);
        chk("midclr_rst_disp", 32'(display_value), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("midclr_nwr",   32'(wr_log.size() - base), 32'd7);
        chk("midclr_busy",  32'(busy), 32'd0);
        chk("midclr_disp0", 32'(display_value), 32'd0);
        for (int i = 1; i < 16; i++) begin
            pulse(C_UP, 16'h0000);
            count_busy(nb);
            chk($sformatf("midclr_disp%0d", i), 32'(display_value),
                (i < 7) ? 32'd0 : 32'(16'hC000 + 16'(i)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_access_sequencer.md
# ram_access_sequencer

Controller that sits between the debounced front-panel buttons and the 16×16 synchronous RAM of the switch-store/seven-segment display design. It owns the RAM port:
- sequences user store and address-select requests;
- runs a bulk-clear engine;
- runs an auto-scan mode that steps through all addresses.

It always presents the contents of the current address to the seven-segment driver.

## Interface
- `ADDR_W`, 4, RAM address width (16 entries)
- `DATA_W`, 16, RAM word width
- `STEP_TICKS`, 50_000_000, clk cycles per auto-scan step (≥2)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `store_pulse`  in  1  one-cycle pulse: write `sw` to current address
- `up_pulse`  in  1  one-cycle pulse: current address +1
- `down_pulse`  in  1  one-cycle pulse: current address −1
- `clear_pulse`  in  1  one-cycle pulse: zero the whole RAM
- `auto_en`  in  1  level: enable auto-scan
- `sw`  in  `DATA_W`  write data
- `ram_we`  out  1  RAM write enable
- `ram_adr`  out  `ADDR_W`  RAM address
- `ram_din`  out  `DATA_W`  RAM write data
- `ram_dout`  in  `DATA_W`  RAM read data, valid one cycle after `ram_adr` (synchronous read)
- `cur_addr`  out  `ADDR_W`  current address, drives the LEDs
- `display_value`  out  `DATA_W`  value to the seven-segment driver
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **States:**
  - IDLE
  - WRITE: `ram_we`=1, `ram_adr`=`cur_addr`, `ram_din`=latched `sw`
  - CLEAR: `ram_we`=1, `ram_adr`=`clr_idx`, `ram_din`=0
  - READ: `ram_adr`=`cur_addr`, `ram_we`=0
  - LATCH: `display_value` ← `ram_dout` at the closing edge
- **`ram_adr` in IDLE/LATCH:** `ram_adr`=`cur_addr`; `ram_we`=0 outside WRITE/CLEAR.
- **IDLE priority, highest first:**
  - `clear_pulse` → CLEAR, `clr_idx`←0.
  - `store_pulse` → WRITE, `sw` latched into the write-data register.
  - Exactly one of `up_pulse`/`down_pulse` → `cur_addr`±1 modulo 16 (15+1→0, 0−1→15), → READ. Both high together → no change, stay IDLE.
  - Auto step due → `cur_addr`+1 modulo 16, → READ.
- **Other transitions:**
  - WRITE → READ.
  - CLEAR: `clr_idx`+1 each cycle. After writing index 15: `cur_addr`←0, → READ.
  - READ → LATCH → IDLE.
- **Pulses while busy:** any pulse arriving while `busy`=1 is dropped, not queued.
- **Auto-scan:**
  - Tick counter counts 0..`STEP_TICKS`−1 while `auto_en`=1 and state=IDLE. It holds in other states.
  - A step is due when the counter = `STEP_TICKS`−1 in IDLE; the counter then returns to 0.
  - `auto_en`=0 clears the counter.
  - Any user up/down/store/clear accepted in IDLE also clears the counter.
  - A step that is due in the same cycle as a user pulse loses to the user pulse.
- **Reset values** (asynchronous):
  - state=READ, so address 0 is loaded after reset
  - `cur_addr`=0, `clr_idx`=0, tick counter=0, write-data register=0
  - `display_value`=0, `ram_we`=0, `ram_adr`=0, `ram_din`=0, `busy`=1
- **Reset during CLEAR:** abandons the clear. Already-zeroed entries stay zero and the rest keep their contents. No recovery is attempted.

## Timing
- Pulse sampled at edge E0 (state IDLE).
- **Up/down:**
  - `cur_addr` new value visible after E0.
  - READ in cycle E0–E1, LATCH in cycle E1–E2.
  - `display_value` updated after E2.
  - `busy` high for 2 cycles.
- **Store:**
  - WRITE cycle E0–E1, READ E1–E2, LATCH E2–E3.
  - `display_value` = new `sw` value after E3.
  - `busy` high for 3 cycles.
- **Clear:**
  - 16 CLEAR cycles, then READ and LATCH.
  - `display_value`=0 and `cur_addr`=0 after E18.
  - `busy` high for 18 cycles.
- **After reset deassert:** `display_value` = RAM[0] after the 2nd edge. `busy` falls after that same edge.
- **Back-to-back pulses:** the earliest acceptance of a next pulse is the first cycle with `busy`=0.

## Test plan
- Reset, `sw`=16'h1234, `store_pulse` → `ram_we` high exactly 1 cycle at addr 0, `din` 16'h1234; `display_value`=16'h1234 3 cycles after pulse.
- `down_pulse` from `cur_addr`=0 → `cur_addr`=15, read issued at addr 15; then `up_pulse` → `cur_addr`=0, `display_value`=16'h1234.
- Store 16'hBEEF at addr 5, then `clear_pulse` → 16 consecutive writes of 0 at addrs 0..15; `busy` 18 cycles; `cur_addr`=0; moving to addr 5 reads 0.
- `up_pulse` and `down_pulse` in the same cycle → no address change, `busy` stays 0. `store_pulse` issued during a clear → ignored, no extra write.
- `STEP_TICKS`=4, `auto_en`=1 → `cur_addr` advances every 4 IDLE cycles plus the 2-cycle read, wrapping 15→0. An `up_pulse` coinciding with a due step gives a single increment and restarts the counter.
- Assert `reset` mid-CLEAR at `clr_idx`=7 → outputs take reset values immediately; addrs 0..6 read 0, addrs 8..15 keep their prior data.
